// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small character FIFO, configurable frame format and a status register
// on the shared processor I/O bus.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            iocs_i,
  input  logic            iorw_i,
  input  logic [1:0]      ioaddr_i,
  inout  wire logic [7:0] databus_io,
  output logic            txd_o,
  output logic            tbr_o
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam logic [2:0]  DataLast = 3'(DATA_BITS - 1);
  localparam logic [2:0]  StopLast = 3'(STOP_BITS - 1);
  localparam logic        ParOdd   = (PARITY == 2);
  localparam logic        ParOn    = (PARITY != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 ovf_q, ovf_d;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;

  logic                 wr, rd, push, pop, fifo_full, fifo_empty, busy;
  logic [DATA_BITS-1:0] head;
  logic [7:0]           status;

  assign wr         = iocs_i & ~iorw_i & (ioaddr_i == 2'b00);
  assign rd         = iocs_i & iorw_i & (ioaddr_i == 2'b01);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rptr_q];
  // A pop in the same cycle frees the slot the write needs.
  assign push       = wr & (~fifo_full | pop);
  assign busy       = (state_q != StIdle);

  assign status     = {ovf_q, busy, fifo_empty, ~fifo_full, 4'(count_q)};
  assign databus_io = rd ? status : 8'bz;
  assign tbr_o      = ~fifo_full;
  assign txd_o      = txd_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CntW'(push) - CntW'(pop);
    ovf_d   = ovf_q;
    if (push) begin
      wptr_d = (wptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    if (rd) begin
      ovf_d = 1'b0;
    end
    if (wr && !push) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    if (enable_i) begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = (^head) ^ ParOdd;
            state_d = StStart;
          end
        end
        StStart: begin
          state_d = StData;
          cnt_d   = '0;
        end
        StData: begin
          if (cnt_q == DataLast) begin
            cnt_d   = '0;
            state_d = ParOn ? StPar : StStop;
          end else begin
            cnt_d   = cnt_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
        StPar: begin
          cnt_d   = '0;
          state_d = StStop;
        end
        StStop: begin
          if (cnt_q == StopLast) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (^head) ^ ParOdd;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Line level is registered from the next state so each bit starts the cycle after its enable.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      StPar:   txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= databus_io[DATA_BITS-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

endmodule
